// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM stage: funct3 width codes, FSM states and
// write-back source select values.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic WB_SEL_ALU  = 1'b0;
    localparam logic WB_SEL_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte-enables/replication, access fault
// detection, and load-data extraction with sign/zero extension.
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_store_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_fault,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic        w_illegal;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        if (i_mem_read && i_mem_write) begin
            w_illegal = 1'b1;
        end else if (i_mem_read) begin
            case (i_funct3)
                F3_LB, F3_LBU: w_misalign = 1'b0;
                F3_LH, F3_LHU: w_misalign = i_offset[0];
                F3_LW:         w_misalign = |i_offset;
                default:       w_illegal  = 1'b1;
            endcase
        end else if (i_mem_write) begin
            case (i_funct3)
                F3_SB:   w_misalign = 1'b0;
                F3_SH:   w_misalign = i_offset[0];
                F3_SW:   w_misalign = |i_offset;
                default: w_illegal  = 1'b1;
            endcase
        end
        o_fault = w_illegal | w_misalign;
    end

    // Store data is replicated across lanes so the memory only needs the BE mask.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        case (i_funct3)
            F3_SB: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_store_data[7:0]}};
            end
            F3_SH: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase
    end

    always_comb begin
        w_byte      = i_rdata[{i_ld_offset, 3'b000} +: 8];
        w_half      = i_ld_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_load_data = i_rdata;
        case (i_ld_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_load_data = {24'd0, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// RISC-V MEM stage: issues loads/stores over a valid/ready request and response
// port, stalls upstream while busy, and hands one bundle per instruction to WB.
module memory_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      MEM_VALID,
    input  logic [DATA_WIDTH-1:0]     ALU_RESULT,
    input  logic [DATA_WIDTH-1:0]     STORE_DATA,
    input  logic                      MEM_READ,
    input  logic                      MEM_WRITE,
    input  logic [2:0]                MEM_FUNCT3,
    input  logic [REG_ADDR_WIDTH-1:0] RD_ADDR,
    input  logic                      REG_WRITE,
    input  logic                      WB_SEL_IN,
    output logic                      STALL_OUT,
    output logic                      DREQ_VALID,
    input  logic                      DREQ_READY,
    output logic [ADDR_WIDTH-1:0]     DREQ_ADDR,
    output logic                      DREQ_WE,
    output logic [3:0]                DREQ_BE,
    output logic [DATA_WIDTH-1:0]     DREQ_WDATA,
    input  logic                      DRSP_VALID,
    input  logic [DATA_WIDTH-1:0]     DRSP_RDATA,
    output logic                      WB_VALID,
    output logic [DATA_WIDTH-1:0]     WB_ALU_RESULT,
    output logic [DATA_WIDTH-1:0]     WB_LOAD_DATA,
    output logic [REG_ADDR_WIDTH-1:0] WB_RD_ADDR,
    output logic                      WB_REG_WRITE,
    output logic                      WB_SEL,
    output logic                      MEM_FAULT
);

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_WIDTH-1:0]     r_req_addr;
    logic                      r_req_we;
    logic [3:0]                r_req_be;
    logic [DATA_WIDTH-1:0]     r_req_wdata;
    logic [2:0]                r_ld_funct3;
    logic [1:0]                r_ld_offset;
    logic [DATA_WIDTH-1:0]     r_alu;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_reg_write;
    logic                      r_sel;

    logic                      r_wb_valid;
    logic [DATA_WIDTH-1:0]     r_wb_alu;
    logic [DATA_WIDTH-1:0]     r_wb_load;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic                      r_wb_reg_write;
    logic                      r_wb_sel;
    logic                      r_wb_fault;

    logic                      w_accept;
    logic                      w_is_mem;
    logic                      w_fault;
    logic                      w_issue;
    logic                      w_handshake;
    logic                      w_rsp_done;
    logic [3:0]                w_be;
    logic [31:0]               w_wdata;
    logic [31:0]               w_load_data;

    load_store_align u_align (
        .i_mem_read   (MEM_READ),
        .i_mem_write  (MEM_WRITE),
        .i_funct3     (MEM_FUNCT3),
        .i_offset     (ALU_RESULT[1:0]),
        .i_store_data (STORE_DATA),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_fault      (w_fault),
        .i_ld_funct3  (r_ld_funct3),
        .i_ld_offset  (r_ld_offset),
        .i_rdata      (DRSP_RDATA),
        .o_load_data  (w_load_data)
    );

    assign w_accept    = (r_state == IDLE) && MEM_VALID;
    assign w_is_mem    = MEM_READ | MEM_WRITE;
    assign w_issue     = w_accept && w_is_mem && !w_fault;
    assign w_handshake = (r_state == REQ) && DREQ_READY;
    assign w_rsp_done  = (r_state == RSP) && DRSP_VALID;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_next_state = REQ;
            REQ:     if (DREQ_READY) w_next_state = r_req_we ? IDLE : RSP;
            RSP:     if (DRSP_VALID) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= IDLE;
            r_req_addr     <= '0;
            r_req_we       <= 1'b0;
            r_req_be       <= 4'd0;
            r_req_wdata    <= '0;
            r_ld_funct3    <= 3'd0;
            r_ld_offset    <= 2'd0;
            r_alu          <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_sel          <= WB_SEL_ALU;
            r_wb_valid     <= 1'b0;
            r_wb_alu       <= '0;
            r_wb_load      <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_sel       <= WB_SEL_ALU;
            r_wb_fault     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wb_valid <= 1'b0;
            r_wb_fault <= 1'b0;

            if (w_accept) begin
                r_alu       <= ALU_RESULT;
                r_rd        <= RD_ADDR;
                r_reg_write <= REG_WRITE;
                r_sel       <= WB_SEL_IN;
                r_ld_funct3 <= MEM_FUNCT3;
                r_ld_offset <= ALU_RESULT[1:0];
                if (w_issue) begin
                    r_req_addr  <= {ALU_RESULT[ADDR_WIDTH-1:2], 2'b00};
                    r_req_we    <= MEM_WRITE;
                    r_req_be    <= w_be;
                    r_req_wdata <= w_wdata;
                end else begin
                    // Non-memory op or faulting access retires immediately.
                    r_wb_valid     <= 1'b1;
                    r_wb_alu       <= ALU_RESULT;
                    r_wb_load      <= '0;
                    r_wb_rd        <= RD_ADDR;
                    r_wb_reg_write <= REG_WRITE & ~(w_is_mem & w_fault);
                    r_wb_sel       <= WB_SEL_IN;
                    r_wb_fault     <= w_is_mem & w_fault;
                end
            end

            if (w_handshake && r_req_we) begin
                r_wb_valid     <= 1'b1;
                r_wb_alu       <= r_alu;
                r_wb_load      <= '0;
                r_wb_rd        <= r_rd;
                r_wb_reg_write <= r_reg_write;
                r_wb_sel       <= r_sel;
            end

            if (w_rsp_done) begin
                r_wb_valid     <= 1'b1;
                r_wb_alu       <= r_alu;
                r_wb_load      <= w_load_data;
                r_wb_rd        <= r_rd;
                r_wb_reg_write <= r_reg_write;
                r_wb_sel       <= r_sel;
            end
        end
    end

    assign STALL_OUT     = (r_state != IDLE);
    assign DREQ_VALID    = (r_state == REQ);
    assign DREQ_ADDR     = r_req_addr;
    assign DREQ_WE       = r_req_we;
    assign DREQ_BE       = r_req_be;
    assign DREQ_WDATA    = r_req_wdata;
    assign WB_VALID      = r_wb_valid;
    assign WB_ALU_RESULT = r_wb_alu;
    assign WB_LOAD_DATA  = r_wb_load;
    assign WB_RD_ADDR    = r_wb_rd;
    assign WB_REG_WRITE  = r_wb_reg_write;
    assign WB_SEL        = r_wb_sel;
    assign MEM_FAULT     = r_wb_fault;

endmodule
